// File: rtl/lt24_picture_blitter.sv
// Raster-scans the LT24 panel and streams one pixel per valid/ready handshake,
// taking colour from a one-cycle-latency picture ROM inside a movable, scaled window.
module lt24_picture_blitter #(
    parameter int          WIDTH      = 240,
    parameter int          HEIGHT     = 320,
    parameter int          X_BITS     = 8,
    parameter int          Y_BITS     = 9,
    parameter int          PIC_WIDTH  = 200,
    parameter int          PIC_HEIGHT = 270,
    parameter int          SCALE_LOG2 = 0,
    parameter int          ADDR_BITS  = 16,
    parameter logic [15:0] BACK_COLOR = 16'h0000,
    parameter int          KEY_ENABLE = 0,
    parameter logic [15:0] KEY_COLOR  = 16'hF81F
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [X_BITS-1:0]    picX,
    input  logic [Y_BITS-1:0]    picY,
    output logic [ADDR_BITS-1:0] romAddr,
    input  logic [15:0]          romData,
    output logic [X_BITS-1:0]    xAddr,
    output logic [Y_BITS-1:0]    yAddr,
    output logic [15:0]          pixelData,
    output logic                 pixelWrite,
    input  logic                 pixelReady,
    output logic                 busy,
    output logic                 frameDone
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, PRESENT} state_t;

    // Window spans carry two extra bits so picX + span never wraps back into the panel.
    localparam logic [X_BITS+1:0]    SPAN_X  = (X_BITS+2)'(PIC_WIDTH << SCALE_LOG2);
    localparam logic [Y_BITS+1:0]    SPAN_Y  = (Y_BITS+2)'(PIC_HEIGHT << SCALE_LOG2);
    localparam logic [X_BITS-1:0]    X_LAST  = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0]    Y_LAST  = Y_BITS'(HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] PIC_W_A = ADDR_BITS'(PIC_WIDTH);

    state_t                state;
    logic [X_BITS-1:0]     pic_x_q;
    logic [Y_BITS-1:0]     pic_y_q;
    logic [X_BITS-1:0]     dx;
    logic [Y_BITS-1:0]     dy;
    logic [ADDR_BITS-1:0]  row_base;
    logic [ADDR_BITS-1:0]  col_off;
    logic                  in_x;
    logic                  in_y;
    logic                  in_window;
    logic                  key_hit;
    logic                  last_pixel;

    always_comb begin
        in_x      = (xAddr >= pic_x_q) && ({2'b00, xAddr} < ({2'b00, pic_x_q} + SPAN_X));
        in_y      = (yAddr >= pic_y_q) && ({2'b00, yAddr} < ({2'b00, pic_y_q} + SPAN_Y));
        in_window = in_x && in_y;
        dx        = xAddr - pic_x_q;
        dy        = yAddr - pic_y_q;
        row_base  = ADDR_BITS'(dy >> SCALE_LOG2) * PIC_W_A;
        col_off   = ADDR_BITS'(dx >> SCALE_LOG2);
        romAddr   = in_window ? (row_base + col_off) : '0;
        key_hit   = (KEY_ENABLE != 0) && (romData == KEY_COLOR);
        last_pixel = (xAddr == X_LAST) && (yAddr == Y_LAST);
        busy      = (state != IDLE);
    end

    // Handshake: a pixel transfers on a rising edge where pixelWrite && pixelReady;
    // pixelWrite never drops and xAddr/yAddr/pixelData never change before that edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            xAddr      <= '0;
            yAddr      <= '0;
            pic_x_q    <= '0;
            pic_y_q    <= '0;
            pixelData  <= BACK_COLOR;
            pixelWrite <= 1'b0;
            frameDone  <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        pic_x_q <= picX;
                        pic_y_q <= picY;
                        xAddr   <= '0;
                        yAddr   <= '0;
                        state   <= FETCH;
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    pixelData  <= (in_window && !key_hit) ? romData : BACK_COLOR;
                    pixelWrite <= 1'b1;
                    state      <= PRESENT;
                end
                PRESENT: begin
                    if (pixelReady) begin
                        pixelWrite <= 1'b0;
                        if (last_pixel) begin
                            frameDone <= 1'b1;
                            xAddr     <= '0;
                            yAddr     <= '0;
                            if (enable) begin
                                pic_x_q <= picX;
                                pic_y_q <= picY;
                                state   <= FETCH;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            if (xAddr == X_LAST) begin
                                xAddr <= '0;
                                yAddr <= yAddr + 1'b1;
                            end else begin
                                xAddr <= xAddr + 1'b1;
                            end
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lt24_picture_blitter.sv
// Bench for lt24_picture_blitter: three parameterisations checked against a
// coordinate-level model of the picture window, ROM and background rules.
module tb_lt24_picture_blitter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  rst;
    logic        enable;
    logic        ready;
    logic [7:0]  pic_x;
    logic [8:0]  pic_y;

    logic [15:0] a_addr, b_addr, c_addr;
    logic [15:0] a_rom, b_rom, c_rom;
    logic [7:0]  a_x, b_x, c_x;
    logic [8:0]  a_y, b_y, c_y;
    logic [15:0] a_data, b_data, c_data;
    logic        a_write, b_write, c_write;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;
    logic [15:0] rom_c [16];

    lt24_picture_blitter #(.WIDTH(240), .HEIGHT(16), .PIC_WIDTH(200), .PIC_HEIGHT(4)) dut_a (
        .clock(clock), .reset(rst[0]), .enable(enable), .picX(pic_x), .picY(pic_y),
        .romAddr(a_addr), .romData(a_rom), .xAddr(a_x), .yAddr(a_y), .pixelData(a_data),
        .pixelWrite(a_write), .pixelReady(ready), .busy(a_busy), .frameDone(a_done));

    lt24_picture_blitter #(.WIDTH(240), .HEIGHT(4), .SCALE_LOG2(1)) dut_b (
        .clock(clock), .reset(rst[1]), .enable(enable), .picX(pic_x), .picY(pic_y),
        .romAddr(b_addr), .romData(b_rom), .xAddr(b_x), .yAddr(b_y), .pixelData(b_data),
        .pixelWrite(b_write), .pixelReady(ready), .busy(b_busy), .frameDone(b_done));

    lt24_picture_blitter #(.WIDTH(16), .HEIGHT(4), .PIC_WIDTH(8), .PIC_HEIGHT(2),
                           .BACK_COLOR(16'h1234), .KEY_ENABLE(1)) dut_c (
        .clock(clock), .reset(rst[2]), .enable(enable), .picX(pic_x), .picY(pic_y),
        .romAddr(c_addr), .romData(c_rom), .xAddr(c_x), .yAddr(c_y), .pixelData(c_data),
        .pixelWrite(c_write), .pixelReady(ready), .busy(c_busy), .frameDone(c_done));

    // ROM models: one clock of read latency.
    always_ff @(posedge clock) begin
        a_rom <= a_addr;
        b_rom <= b_addr;
        c_rom <= (c_addr < 16'd16) ? rom_c[c_addr[3:0]] : 16'h0000;
    end

    int sel;
    logic [7:0]  m_x;
    logic [8:0]  m_y;
    logic [15:0] m_data, m_addr;
    logic        m_write, m_busy, m_done;
    assign m_x     = (sel == 0) ? a_x     : (sel == 1) ? b_x     : c_x;
    assign m_y     = (sel == 0) ? a_y     : (sel == 1) ? b_y     : c_y;
    assign m_data  = (sel == 0) ? a_data  : (sel == 1) ? b_data  : c_data;
    assign m_addr  = (sel == 0) ? a_addr  : (sel == 1) ? b_addr  : c_addr;
    assign m_write = (sel == 0) ? a_write : (sel == 1) ? b_write : c_write;
    assign m_busy  = (sel == 0) ? a_busy  : (sel == 1) ? b_busy  : c_busy;
    assign m_done  = (sel == 0) ? a_done  : (sel == 1) ? b_done  : c_done;

    int cfg_w, cfg_h, cfg_s, cfg_pw, cfg_ph, cfg_key;
    logic [15:0] cfg_back;
    int checks;
    int errors;
    bit hold_pending;

    typedef struct {int x; int y; logic [15:0] d; bit seen;} pt_t;
    pt_t pts[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int s_i, input int w, input int h, input int s,
                           input int pw, input int ph, input int key, input logic [15:0] back);
        sel = s_i; cfg_w = w; cfg_h = h; cfg_s = s; cfg_pw = pw; cfg_ph = ph;
        cfg_key = key; cfg_back = back;
    endtask

    task automatic add_pt(input int x, input int y, input logic [15:0] d);
        pt_t p;
        p.x = x; p.y = y; p.d = d; p.seen = 1'b0;
        pts.push_back(p);
    endtask

    function automatic logic [15:0] rom_word(input int a);
        if (sel == 2) return (a < 16) ? rom_c[a] : 16'h0000;
        return 16'(a);
    endfunction

    // -1 means the coordinate is outside the (clipped) picture window.
    function automatic int ref_addr(input int x, input int y, input int px, input int py);
        int sc;
        sc = 1 << cfg_s;
        if (x >= px && x < px + cfg_pw * sc && y >= py && y < py + cfg_ph * sc)
            return (((y - py) / sc) * cfg_pw + (x - px) / sc) % 65536;
        return -1;
    endfunction

    function automatic logic [15:0] ref_data(input int x, input int y, input int px, input int py);
        int a;
        logic [15:0] d;
        a = ref_addr(x, y, px, py);
        if (a < 0) return cfg_back;
        d = rom_word(a);
        if (cfg_key != 0 && d == 16'hF81F) return cfg_back;
        return d;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " pos"}, {m_x, m_y}, 0);
        check({tag, " data"}, m_data, cfg_back);
        check({tag, " write"}, m_write, 0);
        check({tag, " romAddr"}, m_addr, 0);
        check({tag, " busy"}, m_busy, 0);
        check({tag, " done"}, m_done, 0);
    endtask

    // Called on the negedge where enable is first driven high with the block idle.
    task automatic start_latency(input string tag, input int px, input int py);
        @(negedge clock);
        check({tag, " c1 write/busy"}, {m_write, m_busy}, 2'b01);
        @(negedge clock);
        check({tag, " c2 write"}, m_write, 0);
        @(negedge clock);
        check({tag, " c3 write"}, m_write, 1);
        check({tag, " c3 pos"}, {m_x, m_y}, 0);
        check({tag, " c3 data"}, m_data, ref_data(0, 0, px, py));
    endtask

    task automatic run_frame(input string tag, input int px, input int py,
                             input int chg_row, input int new_px, input int new_py,
                             input int drop_row, input int ready_pct);
        int ex, ey, accepts, gap, hold, a;
        bit last_acc, prev_wait, done_seen;
        logic [63:0] snap;
        ex = 0; ey = 0; accepts = 0; gap = -1; hold = 0; done_seen = 0;
        for (int cyc = 0; cyc < cfg_w * cfg_h * 6 + 100; cyc++) begin
            last_acc = 0;
            if (hold > 0) begin
                ready = 0;
                hold--;
            end else if (hold_pending && m_write && m_x == 8'd5 && m_y == 9'd0) begin
                ready = 0;
                hold = 19;
                hold_pending = 0;
            end else begin
                ready = (int'($urandom_range(0, 99)) < ready_pct);
            end
            prev_wait = m_write && !ready;
            snap = 64'({m_write, m_x, m_y, m_data, m_addr});
            if (m_write && ready) begin
                a = ref_addr(ex, ey, px, py);
                check($sformatf("%s pos #%0d", tag, accepts), {m_x, m_y}, {8'(ex), 9'(ey)});
                check($sformatf("%s data (%0d,%0d)", tag, ex, ey), m_data, ref_data(ex, ey, px, py));
                check($sformatf("%s romAddr (%0d,%0d)", tag, ex, ey), m_addr, (a < 0) ? 0 : a);
                foreach (pts[i]) begin
                    if (pts[i].x == ex && pts[i].y == ey) begin
                        check($sformatf("%s point (%0d,%0d)", tag, ex, ey), m_data, pts[i].d);
                        pts[i].seen = 1'b1;
                    end
                end
                if (ey == chg_row && ex == 0) begin
                    pic_x = 8'(new_px);
                    pic_y = 9'(new_py);
                end
                if (ey == drop_row && ex == 0) enable = 0;
                last_acc = (ex == cfg_w - 1 && ey == cfg_h - 1);
                accepts++;
                gap = last_acc ? -1 : 0;
                ex++;
                if (ex == cfg_w) begin
                    ex = 0;
                    ey++;
                end
            end
            @(negedge clock);
            if (prev_wait) check({tag, " stall hold"}, 64'({m_write, m_x, m_y, m_data, m_addr}), snap);
            if (gap >= 0) begin
                gap++;
                if (gap < 3) begin
                    check({tag, " gap write low"}, m_write, 0);
                end else begin
                    check({tag, " next write"}, m_write, 1);
                    gap = -1;
                end
            end
            check({tag, " frameDone"}, m_done, last_acc);
            if (last_acc) begin
                done_seen = 1;
                break;
            end
        end
        check({tag, " frame completed"}, done_seen, 1);
        check({tag, " accepts"}, accepts, cfg_w * cfg_h);
        check({tag, " busy after frame"}, m_busy, (drop_row >= 0) ? 0 : 1);
        foreach (pts[i]) check($sformatf("%s point (%0d,%0d) seen", tag, pts[i].x, pts[i].y), pts[i].seen, 1);
        pts.delete();
    endtask

    initial begin
        int k, px, py, npx, npy;
        checks = 0; errors = 0; hold_pending = 0;
        rst = 3'b111; enable = 0; ready = 0; pic_x = 8'd10; pic_y = 9'd10;
        for (int i = 0; i < 16; i++) begin
            rom_c[i] = 16'($urandom);
            if (rom_c[i] == 16'hF81F) rom_c[i] = 16'hF81E;
        end
        rom_c[5] = 16'hF81F;

        // Instance A: unscaled window, mid-frame picX change, stall at (5,0).
        set_cfg(0, 240, 16, 0, 200, 4, 0, 16'h0000);
        repeat (3) @(negedge clock);
        check_reset("A reset");
        enable = 1; rst[0] = 0;
        start_latency("A start", 10, 10);
        add_pt(10, 10, 16'd0); add_pt(209, 10, 16'd199); add_pt(10, 11, 16'd200);
        add_pt(210, 10, 16'h0000); add_pt(10, 14, 16'h0000); add_pt(210, 13, 16'h0000);
        hold_pending = 1;
        run_frame("A f1", 10, 10, 12, 200, 10, -1, 80);
        check("A hold applied", hold_pending, 0);
        add_pt(239, 10, 16'd39); add_pt(0, 10, 16'h0000);
        run_frame("A f2", 200, 10, -1, 0, 0, 14, 80);
        @(negedge clock);
        check("A idle write", {m_write, m_busy}, 0);
        rst[0] = 1;

        // Instance B: scale factor 2.
        set_cfg(1, 240, 4, 1, 200, 270, 0, 16'h0000);
        pic_x = 0; pic_y = 0;
        @(negedge clock);
        check_reset("B reset");
        enable = 1; rst[1] = 0;
        start_latency("B start", 0, 0);
        add_pt(0, 0, 16'd0); add_pt(1, 0, 16'd0); add_pt(0, 1, 16'd0); add_pt(1, 1, 16'd0);
        add_pt(2, 0, 16'd1); add_pt(0, 2, 16'd200); add_pt(200, 0, 16'd100);
        run_frame("B f1", 0, 0, -1, 0, 0, 2, 75);
        rst[1] = 1;

        // Instance C: colour key, mid-frame reset, randomly placed windows.
        set_cfg(2, 16, 4, 0, 8, 2, 1, 16'h1234);
        @(negedge clock);
        check_reset("C reset");
        enable = 1; rst[2] = 0;
        start_latency("C start", 0, 0);
        ready = 1;
        k = int'($urandom_range(5, 40));
        repeat (k) @(negedge clock);
        rst[2] = 1;
        #1;
        check_reset("C mid-frame reset");
        @(negedge clock);
        rst[2] = 0;
        start_latency("C restart", 0, 0);
        add_pt(5, 0, 16'h1234);
        px = 0; py = 0;
        for (int f = 0; f < 5; f++) begin
            npx = int'($urandom_range(0, 15));
            npy = int'($urandom_range(0, 3));
            run_frame($sformatf("C f%0d", f), px, py, 1, npx, npy, (f == 4) ? 2 : -1, 70);
            px = npx; py = npy;
        end
        rst[2] = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lt24_picture_blitter.md
# lt24_picture_blitter

Parametrised picture generator for the LT24 pixel-mode interface. It raster-scans the full panel and, per pixel, fetches from a single-cycle-latency picture ROM whenever the scan is inside a movable, integer-scaled picture window; everywhere else it emits a background colour. Each pixel is offered on a valid/ready handshake, so coordinates and data always stay aligned. It sits between the picture ROM and the display core's `xAddr/yAddr/pixelData/pixelWrite/pixelReady` port, and replaces ad-hoc counter-plus-ROM glue in top levels.

## Interface
- `WIDTH`, 240: panel width in pixels.
- `HEIGHT`, 320: panel height in pixels.
- `X_BITS`, 8: width of x coordinates.
- `Y_BITS`, 9: width of y coordinates.
- `PIC_WIDTH`, 200: picture width in ROM pixels.
- `PIC_HEIGHT`, 270: picture height in ROM pixels.
- `SCALE_LOG2`, 0: on-screen scale factor is 1<<SCALE_LOG2. Legal values are 0, 1 and 2.
- `ADDR_BITS`, 16: ROM address width.
- `BACK_COLOR`, 16'h0000: RGB565 colour outside the window.
- `KEY_ENABLE`, 0: when 1, ROM data equal to `KEY_COLOR` is replaced by `BACK_COLOR`.
- `KEY_COLOR`, 16'hF81F: transparent colour key.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: run frames while high.
- `picX`  in  X_BITS: window left edge. Sampled at frame start.
- `picY`  in  Y_BITS: window top edge. Sampled at frame start.
- `romAddr`  out  ADDR_BITS: picture ROM address. Combinational from the current scan position.
- `romData`  in  16: ROM output. Valid one clock after the address is presented.
- `xAddr`  out  X_BITS: current pixel x.
- `yAddr`  out  Y_BITS: current pixel y.
- `pixelData`  out  16: current pixel colour.
- `pixelWrite`  out  1: pixel valid.
- `pixelReady`  in  1: display accepts the pixel.
- `busy`  out  1: high while not in IDLE.
- `frameDone`  out  1: one-cycle pulse when the last pixel of a frame is accepted.

## Operation
- The FSM has four states: IDLE, FETCH, CAPTURE and PRESENT.
  - IDLE: if `enable` is high, latch `picX`/`picY`, clear the scan position to (0,0) and go to FETCH.
  - FETCH: `romAddr` is valid for the scan position. Go to CAPTURE.
  - CAPTURE: `romData` is valid. Register `pixelData`, then go to PRESENT.
  - PRESENT: `pixelWrite` is 1. The pixel is accepted when `pixelWrite` and `pixelReady` are both high.
    - If the pixel is not the last one, advance the scan and go to FETCH.
    - If it is the last one (WIDTH-1, HEIGHT-1), pulse `frameDone` and the scan returns to (0,0).
    - After the last pixel, go to FETCH if `enable` is high (re-latch `picX`/`picY` first), otherwise go to IDLE.
- Scan order is x fastest, running 0..WIDTH-1. At x = WIDTH-1, x wraps to 0 and y increments.
- `xAddr`/`yAddr` are the registered scan position. They are stable from FETCH through acceptance.
- Window test: `picX` <= x < `picX` + (PIC_WIDTH<<SCALE_LOG2), and `picY` <= y < `picY` + (PIC_HEIGHT<<SCALE_LOG2).
  - Evaluate the test with 2 extra bits so the window end never wraps.
  - Any part of the window beyond the panel is clipped. It never wraps to the left or top edge.
- Inside the window, `romAddr` = ((y-`picY`)>>SCALE_LOG2)*PIC_WIDTH + ((x-`picX`)>>SCALE_LOG2), truncated to ADDR_BITS. Outside the window, `romAddr` = 0.
- `pixelData` selection:
  - Inside the window with the key matched (KEY_ENABLE=1 and `romData` == KEY_COLOR): BACK_COLOR.
  - Inside the window otherwise: `romData`.
  - Outside the window: BACK_COLOR.
- Dropping `enable` mid-frame does not stop the block. The current frame always completes.

## Timing
- Reset values: `xAddr`=0, `yAddr`=0, `pixelData`=BACK_COLOR, `pixelWrite`=0, `romAddr`=0, `busy`=0, `frameDone`=0, state IDLE.
- Reset asserted mid-frame returns the block to these values immediately. No pixel completes.
- Start latency: `enable` is seen in IDLE at cycle 0, FETCH is cycle 1, CAPTURE is cycle 2, and `pixelWrite` rises in cycle 3.
- Per-pixel minimum is 3 cycles (FETCH, CAPTURE, PRESENT with `pixelReady`=1). A full frame therefore takes at least 3*WIDTH*HEIGHT cycles.
- `pixelReady` is only sampled in PRESENT. While waiting in PRESENT, all outputs hold.
- `frameDone` is asserted in the cycle after the accepting edge, for exactly 1 cycle.

## Test plan
- Reset: hold `reset` → all outputs equal their reset values.
  - Release `reset` with `enable`=1 → `pixelWrite` rises on the 3rd clock after IDLE sees `enable`, with `xAddr`=0, `yAddr`=0, `pixelData`=BACK_COLOR.
- Full frame, defaults, `picX`=10, `picY`=10, `pixelReady`=1, ROM model returning data = address:
  - exactly 76800 accepts and one `frameDone` pulse;
  - pixel (10,10) → data 0;
  - pixel (209,10) → data 199;
  - pixel (10,11) → data 200;
  - pixel (210,10) → BACK_COLOR;
  - pixel (10,280) → BACK_COLOR.
- Backpressure: hold `pixelReady`=0 for 20 cycles in PRESENT at (5,0) → outputs stable, no advance. Then `pixelReady`=1 → next pixel (6,0) appears 3 cycles later.
- Clipping and re-latch: `picX`=200 → pixel (239,10) gives data 39 and pixel (0,10) gives BACK_COLOR. Change `picX` mid-frame → no effect until the next frame start.
- SCALE_LOG2=1, `picX`=`picY`=0:
  - pixels (0,0), (1,0), (0,1) and (1,1) → all data 0;
  - pixel (2,0) → data 1;
  - pixel (0,2) → data 200;
  - pixel (200,0) → data 100.
- KEY_ENABLE=1, ROM returning 16'hF81F at address 5 → window pixel at offset 5 gives BACK_COLOR. Assert `reset` mid-frame → immediate reset values; with `enable` still high, the next frame restarts at (0,0).
